// File: rtl/clk_div_multi.sv
// Multi-channel reprogrammable integer clock divider with glitch-free ratio changes.
// Optional macro CLK_DIV_ODD_DUTY_EN adds a negedge stage for exact 50% duty on odd ratios.
module clk_div_multi #(
  parameter int NUM_CH        = 4,
  parameter int RATIO_WIDTH   = 8,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CH-1:0]             i_en,
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
  input  logic [NUM_CH-1:0]             i_ratio_load,
  input  logic                          i_sync,
  output logic [NUM_CH-1:0]             o_clk,
  output logic [NUM_CH-1:0]             o_tick,
  output logic [NUM_CH-1:0]             o_pending
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STOP   = 2'd2;
  localparam logic [1:0] ST_BYPASS = 2'd3;

  localparam logic [RATIO_WIDTH-1:0] RATIO_DEF = RATIO_WIDTH'(DEFAULT_RATIO);
  localparam logic [RATIO_WIDTH-1:0] RATIO_ONE = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] RATIO_TWO = RATIO_WIDTH'(2);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [RATIO_WIDTH-1:0] act;
    logic [RATIO_WIDTH-1:0] act_nx;
    logic [RATIO_WIDTH-1:0] pend;
    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] cnt_nx;
    logic [RATIO_WIDTH-1:0] last;
    logic [RATIO_WIDTH-1:0] slice;
    logic                   flag;
    logic                   flag_nx;
    logic                   boundary;
    logic                   restart;
    logic                   running_nx;
    logic                   clk_hi;
    logic                   tick;

    assign slice      = i_div_ratio[k*RATIO_WIDTH +: RATIO_WIDTH];
    assign last       = act - RATIO_ONE;
    assign boundary   = (cnt == last);
    assign restart    = boundary || i_sync;
    assign running_nx = (state_nx == ST_RUN) || (state_nx == ST_STOP);

    // STOP behaves exactly like RUN except that it exits to IDLE at the
    // period boundary, which is what guarantees a full final low phase.
    always_comb begin
      state_nx = state;
      act_nx   = act;
      cnt_nx   = cnt;
      flag_nx  = flag;
      case (state)
        ST_IDLE: begin
          cnt_nx = '0;
          if (flag) begin
            act_nx  = pend;
            flag_nx = 1'b0;
          end
          if (i_en[k]) begin
            state_nx = (act_nx >= RATIO_TWO) ? ST_RUN : ST_BYPASS;
          end
        end
        ST_RUN, ST_STOP: begin
          cnt_nx = restart ? '0 : cnt + RATIO_ONE;
          if (flag && restart) begin
            act_nx  = pend;
            flag_nx = 1'b0;
          end
          if (flag && restart && (pend < RATIO_TWO)) begin
            state_nx = i_en[k] ? ST_BYPASS : ST_IDLE;
          end else if (!i_en[k]) begin
            state_nx = boundary ? ST_IDLE : ST_STOP;
          end else begin
            state_nx = ST_RUN;
          end
        end
        default: begin
          cnt_nx = '0;
          if (flag) begin
            act_nx  = pend;
            flag_nx = 1'b0;
          end
          if (!i_en[k]) begin
            state_nx = ST_IDLE;
          end else if (act_nx >= RATIO_TWO) begin
            state_nx = ST_RUN;
          end
        end
      endcase
      // A load on the apply edge re-arms the flag with the freshly captured value.
      if (i_ratio_load[k]) begin
        flag_nx = 1'b1;
      end
    end

    // Outputs are decoded from the next-state values so they line up with cnt.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state  <= ST_IDLE;
        act    <= RATIO_DEF;
        pend   <= RATIO_DEF;
        cnt    <= '0;
        flag   <= 1'b0;
        clk_hi <= 1'b0;
        tick   <= 1'b0;
      end else begin
        state  <= state_nx;
        act    <= act_nx;
        cnt    <= cnt_nx;
        flag   <= flag_nx;
        clk_hi <= running_nx && (cnt_nx < (act_nx >> 1));
        tick   <= running_nx ? (cnt_nx == '0) : (state_nx == ST_BYPASS);
        if (i_ratio_load[k]) begin
          pend <= slice;
        end
      end
    end

    assign o_tick[k]    = tick;
    assign o_pending[k] = flag;

`ifdef CLK_DIV_ODD_DUTY_EN
    logic neg_hi;

    // Half-cycle extension of the high phase, only meaningful for odd ratios.
    always_ff @(negedge i_clk) begin
      if (i_rst) begin
        neg_hi <= 1'b0;
      end else begin
        neg_hi <= clk_hi && act[0] && (act >= RATIO_TWO);
      end
    end

    assign o_clk[k] = (state == ST_BYPASS) ? i_clk : (clk_hi | neg_hi);
`else
    assign o_clk[k] = (state == ST_BYPASS) ? i_clk : clk_hi;
`endif
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: vector table, directed corner sequences and a
// randomized run checked against a period/position reference model.
module tb_clk_div_multi;

   localparam int NUM_CH = 4;
   localparam int RW     = 8;
   localparam int DEF    = 2;

   logic                 i_clk = 1'b0;
   logic                 i_rst;
   logic [NUM_CH-1:0]    i_en;
   logic [NUM_CH*RW-1:0] i_div_ratio;
   logic [NUM_CH-1:0]    i_ratio_load;
   logic                 i_sync;
   logic [NUM_CH-1:0]    o_clk;
   logic [NUM_CH-1:0]    o_tick;
   logic [NUM_CH-1:0]    o_pending;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 counting (running or winding down), 2 bypass
   int m_mode[NUM_CH];
   int m_pos[NUM_CH];
   int m_ratio[NUM_CH];
   int m_pend[NUM_CH];
   bit m_has[NUM_CH];
   bit m_neg[NUM_CH];

   typedef struct {
      logic              rst;
      logic [NUM_CH-1:0] en;
      logic [NUM_CH-1:0] load;
      logic [31:0]       ratio;
      logic              sync;
      logic [NUM_CH-1:0] eClk;
      logic [NUM_CH-1:0] eTick;
      logic [NUM_CH-1:0] ePend;
   } vec_t;

   vec_t vecs[24];

   always #5 i_clk = ~i_clk;

   clk_div_multi #(
      .NUM_CH(NUM_CH),
      .RATIO_WIDTH(RW),
      .DEFAULT_RATIO(DEF)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_en(i_en),
      .i_div_ratio(i_div_ratio),
      .i_ratio_load(i_ratio_load),
      .i_sync(i_sync),
      .o_clk(o_clk),
      .o_tick(o_tick),
      .o_pending(o_pending)
   );

   // Compare one 4-bit output vector against its expected value
   task automatic checkOutput(input string name, input logic [NUM_CH-1:0] got,
                              input logic [NUM_CH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // Advance the model by one source-clock edge using the inputs seen at that edge
   task automatic modelUpdate();
      for (int k = 0; k < NUM_CH; k++) begin
         bit en;
         bit hi;
         bit wrap;
         en = i_en[k];
         hi = (m_mode[k] == 1) && (m_pos[k] < m_ratio[k] / 2);
         m_neg[k] = i_rst ? 1'b0 : (hi && (m_ratio[k] % 2 == 1) && (m_ratio[k] >= 3));
         if (i_rst) begin
            m_mode[k]  = 0;
            m_pos[k]   = 0;
            m_ratio[k] = DEF;
            m_pend[k]  = DEF;
            m_has[k]   = 1'b0;
            continue;
         end
         if (m_mode[k] == 0 || m_mode[k] == 2) begin
            if (m_has[k]) begin
               m_ratio[k] = m_pend[k];
               m_has[k]   = 1'b0;
            end
            if (!en) begin
               m_mode[k] = 0;
            end else if (m_ratio[k] >= 2) begin
               m_mode[k] = 1;
            end else begin
               m_mode[k] = 2;
            end
            m_pos[k] = 0;
         end else begin
            wrap = ((m_pos[k] + 1) % m_ratio[k]) == 0;
            if (wrap || i_sync) begin
               m_pos[k] = 0;
               if (m_has[k]) begin
                  m_ratio[k] = m_pend[k];
                  m_has[k]   = 1'b0;
                  if (m_ratio[k] < 2) m_mode[k] = en ? 2 : 0;
               end
               if (m_mode[k] == 1 && !en && wrap) m_mode[k] = 0;
            end else begin
               m_pos[k] = m_pos[k] + 1;
            end
         end
         if (i_ratio_load[k]) begin
            m_pend[k] = int'(i_div_ratio[k*RW +: RW]);
            m_has[k]  = 1'b1;
         end
      end
   endtask

   function automatic logic [NUM_CH-1:0] expClk();
      logic [NUM_CH-1:0] r;
      for (int k = 0; k < NUM_CH; k++) begin
         r[k] = (m_mode[k] == 2) || ((m_mode[k] == 1) && (m_pos[k] < m_ratio[k] / 2));
`ifdef CLK_DIV_ODD_DUTY_EN
         r[k] = r[k] | m_neg[k];
`endif
      end
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] expTick();
      logic [NUM_CH-1:0] r;
      for (int k = 0; k < NUM_CH; k++)
         r[k] = (m_mode[k] == 2) || ((m_mode[k] == 1) && (m_pos[k] == 0));
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] expPend();
      logic [NUM_CH-1:0] r;
      for (int k = 0; k < NUM_CH; k++) r[k] = m_has[k];
      return r;
   endfunction

   // One clock: edge, model update, sample 1 ns later (i_clk high)
   task automatic applyStimulus(input bit cmpModel);
      @(posedge i_clk);
      modelUpdate();
      #1;
      if (cmpModel) begin
         checkOutput("model_clk", o_clk, expClk());
         checkOutput("model_tick", o_tick, expTick());
         checkOutput("model_pend", o_pending, expPend());
      end
   endtask

   task automatic setIn(input logic rst, input logic [3:0] en, input logic [3:0] load,
                        input logic [31:0] ratio, input logic sync);
      i_rst        = rst;
      i_en         = en;
      i_ratio_load = load;
      i_div_ratio  = ratio;
      i_sync       = sync;
   endtask

   task automatic doReset();
      setIn(1'b1, 4'b0, 4'b0, 32'h0, 1'b0);
      applyStimulus(1'b1);
      i_rst = 1'b0;
   endtask

   initial begin
      int n;
      int hiCnt;
      int loCnt;
      int guard;
      realtime tRise;
      realtime tFall;
      realtime tRise2;

      setIn(1'b1, 4'b0, 4'b0, 32'h0, 1'b0);

      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 32'h0,        1'b0, 4'b0001, 4'b0001, 4'b0000};
      vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 32'h0,        1'b0, 4'b0001, 4'b0001, 4'b0000};
      vecs[4]  = '{1'b0, 4'b0001, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[5]  = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0011, 4'b0011, 4'b0000};
      vecs[6]  = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[7]  = '{1'b0, 4'b0011, 4'b0010, 32'h00000400, 1'b0, 4'b0011, 4'b0011, 4'b0010};
      vecs[8]  = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0010};
      vecs[9]  = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0011, 4'b0011, 4'b0000};
      vecs[10] = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0010, 4'b0000, 4'b0000};
      vecs[11] = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0001, 4'b0001, 4'b0000};
      vecs[12] = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[13] = '{1'b0, 4'b0011, 4'b0000, 32'h0,        1'b0, 4'b0011, 4'b0011, 4'b0000};
      vecs[14] = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0010, 4'b0000, 4'b0000};
      vecs[15] = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[16] = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[17] = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[18] = '{1'b0, 4'b1000, 4'b1000, 32'h01000000, 1'b0, 4'b1000, 4'b1000, 4'b1000};
      vecs[19] = '{1'b0, 4'b1000, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b1000};
      vecs[20] = '{1'b0, 4'b1000, 4'b0000, 32'h0,        1'b0, 4'b1000, 4'b1000, 4'b0000};
      vecs[21] = '{1'b0, 4'b1000, 4'b0000, 32'h0,        1'b0, 4'b1000, 4'b1000, 4'b0000};
      vecs[22] = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[23] = '{1'b1, 4'b1111, 4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000};

      // Vector table: reset, ch0 at /2, ch1 reload 2->4, stop, ch3 into bypass, reset
      for (int i = 0; i < 24; i++) begin
         setIn(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].ratio, vecs[i].sync);
         applyStimulus(1'b0);
         checkOutput($sformatf("vec%0d_clk", i), o_clk, vecs[i].eClk);
         checkOutput($sformatf("vec%0d_tick", i), o_tick, vecs[i].eTick);
         checkOutput($sformatf("vec%0d_pend", i), o_pending, vecs[i].ePend);
      end

      // Pending window and first period after a 4 -> 6 reload on ch1
      doReset();
      setIn(1'b0, 4'b0000, 4'b0010, 32'h00000400, 1'b0);
      applyStimulus(1'b1);
      i_ratio_load = 4'b0;
      applyStimulus(1'b1);
      i_en = 4'b0010;
      applyStimulus(1'b1);
      setIn(1'b0, 4'b0010, 4'b0010, 32'h00000600, 1'b0);
      applyStimulus(1'b1);
      i_ratio_load = 4'b0;
      n = 0;
      guard = 0;
      while (o_pending[1] && guard < 20) begin
         n++;
         guard++;
         applyStimulus(1'b1);
      end
      checkOutput("pend_window", 4'(n), 4'd3);
      hiCnt = 0;
      loCnt = 0;
      guard = 0;
      while (o_clk[1] && guard < 20) begin hiCnt++; guard++; applyStimulus(1'b1); end
      while (!o_clk[1] && guard < 20) begin loCnt++; guard++; applyStimulus(1'b1); end
      checkOutput("n6_high", 4'(hiCnt), 4'd3);
      checkOutput("n6_low", 4'(loCnt), 4'd3);

      // Ch0 at /8: drop enable mid-period, then re-raise during the wind-down
      doReset();
      setIn(1'b0, 4'b0000, 4'b0001, 32'h00000008, 1'b0);
      applyStimulus(1'b1);
      i_ratio_load = 4'b0;
      applyStimulus(1'b1);
      i_en = 4'b0001;
      repeat (3) applyStimulus(1'b1);
      i_en = 4'b0000;
      repeat (12) applyStimulus(1'b1);
      checkOutput("stop_idle_tick", o_tick, 4'b0000);
      i_en = 4'b0001;
      repeat (3) applyStimulus(1'b1);
      i_en = 4'b0000;
      repeat (3) applyStimulus(1'b1);
      i_en = 4'b0001;
      repeat (10) applyStimulus(1'b1);

      // Ch0 /3 and ch1 /7 brought into phase by a sync pulse
      doReset();
      setIn(1'b0, 4'b0000, 4'b0011, 32'h00000703, 1'b0);
      applyStimulus(1'b1);
      i_ratio_load = 4'b0;
      applyStimulus(1'b1);
      i_en = 4'b0011;
      repeat (6) applyStimulus(1'b1);
      i_sync = 1'b1;
      applyStimulus(1'b1);
      i_sync = 1'b0;
      checkOutput("sync_tick", {2'b00, o_tick[1:0]}, 4'b0011);
      repeat (4) applyStimulus(1'b1);

      // Ch2 at /5: measure the high and low phase in ns
      doReset();
      setIn(1'b0, 4'b0000, 4'b0100, 32'h00050000, 1'b0);
      applyStimulus(1'b1);
      i_ratio_load = 4'b0;
      applyStimulus(1'b1);
      i_en = 4'b0100;
      applyStimulus(1'b1);
      tRise = 0;
      tFall = 0;
      tRise2 = 0;
      guard = 0;
      while (o_clk[2] && guard < 200) begin #1; guard++; end
      while (!o_clk[2] && guard < 200) begin #1; guard++; end
      tRise = $realtime;
      while (o_clk[2] && guard < 200) begin #1; guard++; end
      tFall = $realtime;
      while (!o_clk[2] && guard < 200) begin #1; guard++; end
      tRise2 = $realtime;
      checkOutput("duty_timeout", 4'(guard >= 200), 4'd0);
`ifdef CLK_DIV_ODD_DUTY_EN
      checkOutput("n5_high_ns", 4'(int'(tFall - tRise) / 5), 4'd5);
      checkOutput("n5_low_ns", 4'(int'(tRise2 - tFall) / 5), 4'd5);
`else
      checkOutput("n5_high_ns", 4'(int'(tFall - tRise) / 5), 4'd4);
      checkOutput("n5_low_ns", 4'(int'(tRise2 - tFall) / 5), 4'd6);
`endif

      // Randomized traffic against the model
      @(posedge i_clk);
      #1;
      doReset();
      for (int c = 0; c < 3000; c++) begin
         i_rst  = ($urandom_range(0, 299) == 0);
         i_sync = ($urandom_range(0, 39) == 0);
         for (int k = 0; k < NUM_CH; k++) begin
            if ($urandom_range(0, 15) == 0) i_en[k] = ~i_en[k];
            i_ratio_load[k] = ($urandom_range(0, 24) == 0);
            i_div_ratio[k*RW +: RW] = RW'($urandom_range(0, 9));
         end
         applyStimulus(1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
